// File: rtl/lv_chk_pkg.sv
// Shared types for the local-variable capture checker: per-arm state,
// failure cause encoding, the per-slot state record and a popcount helper.
package lv_chk_pkg;

    // Storage bounds for the slot record; the checker's WIDTH must not exceed
    // V_MAX_W and MAX_LEN must fit in LEN_MAX_W bits. Unused upper bits stay zero.
    localparam int V_MAX_W   = 64;
    localparam int LEN_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arm_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ARM_A   = 2'd1,
        ARM_C   = 2'd2,
        TIMEOUT = 2'd3
    } fail_code_e;

    typedef struct packed {
        logic                 active;
        logic [V_MAX_W-1:0]   v;
        arm_state_e           arm_a;
        arm_state_e           arm_c;
        logic [LEN_MAX_W-1:0] len;
    } slot_t;

    function automatic int unsigned popcount(input logic [63:0] x);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lv_chk_slot.sv
// One attempt evaluator. Holds the captured value v and runs both arms
// against it every cycle while active; reports a combinational resolution
// in the cycle the attempt ends and frees itself on the same clock edge.
// The whole slot state lives in the struct 'st' so it can be probed directly.
module lv_chk_slot
    import lv_chk_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_FAIL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] a,
    input  logic             b,
    input  logic             c,
    input  logic [WIDTH-1:0] d,
    output logic             active,
    output logic             res_pass,
    output logic             res_fail,
    output logic [1:0]       res_code
);

    localparam logic [LEN_MAX_W-1:0] LEN_LIMIT = LEN_MAX_W'(MAX_LEN);

    slot_t                st;
    arm_state_e           a_nxt;
    arm_state_e           c_nxt;
    logic                 a_bad;
    logic                 c_bad;
    logic [V_MAX_W-1:0]   a_x;
    logic [V_MAX_W-1:0]   d_x;
    logic [LEN_MAX_W-1:0] len_nxt;
    fail_code_e           code;

    assign active   = st.active;
    assign res_code = code;

    // Per-cycle arm evaluation and resolution (fail priority: arm A, arm C, then pass, then timeout)
    always_comb begin
        a_x      = V_MAX_W'(a);
        d_x      = V_MAX_W'(d);
        a_nxt    = st.arm_a;
        c_nxt    = st.arm_c;
        a_bad    = 1'b0;
        c_bad    = 1'b0;
        len_nxt  = st.len + LEN_MAX_W'(1);
        res_pass = 1'b0;
        res_fail = 1'b0;
        code     = NONE;
        if (st.active) begin
            if (st.arm_a == RUN) begin
                if (a_x != st.v)  a_nxt = DONE;
                else if (!b)      a_bad = 1'b1;
            end
            if (st.arm_c == RUN) begin
                if (!c)                c_nxt = DONE;
                else if (d_x != st.v)  c_bad = 1'b1;
            end
            if (a_bad) begin
                res_fail = 1'b1;
                code     = ARM_A;
            end else if (c_bad) begin
                res_fail = 1'b1;
                code     = ARM_C;
            end else if (a_nxt == DONE && c_nxt == DONE) begin
                res_pass = 1'b1;
            end else if (len_nxt == LEN_LIMIT) begin
                if (TIMEOUT_FAIL != 0) begin
                    res_fail = 1'b1;
                    code     = TIMEOUT;
                end else begin
                    res_pass = 1'b1;
                end
            end
        end
    end

    // Slot state: capture v on allocation, advance arms while active, free on resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
        end else if (st.active) begin
            if (res_pass || res_fail) begin
                st.active <= 1'b0;
                st.arm_a  <= IDLE;
                st.arm_c  <= IDLE;
                st.len    <= '0;
            end else begin
                st.arm_a <= a_nxt;
                st.arm_c <= c_nxt;
                st.len   <= len_nxt;
            end
        end else if (alloc) begin
            st.active <= 1'b1;
            st.v      <= V_MAX_W'(e);
            st.arm_a  <= RUN;
            st.arm_c  <= RUN;
            st.len    <= '0;
        end
    end

endmodule

// File: rtl/lv_capture_checker.sv
// Multi-attempt monitor for (a==v)[*1:$] |-> b and c[*1:$] |-> d==v with v
// captured from e at each trigger. Allocates attempts to the lowest free
// slot, registers per-slot pass/fail pulses and keeps saturating statistics.
module lv_capture_checker
    import lv_chk_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_FAIL = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               trig,
    input  logic [WIDTH-1:0]   e,
    input  logic [WIDTH-1:0]   a,
    input  logic               b,
    input  logic               c,
    input  logic [WIDTH-1:0]   d,
    output logic [DEPTH-1:0]   pass_vec,
    output logic [DEPTH-1:0]   fail_vec,
    output logic [2*DEPTH-1:0] fail_code,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               overflow,
    output logic               busy
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [DEPTH-1:0]   slot_active;
    logic [DEPTH-1:0]   slot_alloc;
    logic [DEPTH-1:0]   res_pass;
    logic [DEPTH-1:0]   res_fail;
    logic [2*DEPTH-1:0] res_code;
    logic               req;
    logic               drop;
    logic [CNT_W:0]     pass_sum;
    logic [CNT_W:0]     fail_sum;

    // Free-ness is judged on registered flags, so a slot freed this cycle is not reused until next
    assign req  = trig & en;
    assign drop = req & (&slot_active);
    assign busy = |slot_active;

    // Lowest-index free slot takes the new attempt (descending scan, last hit wins)
    always_comb begin
        slot_alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req && !slot_active[i]) begin
                slot_alloc    = '0;
                slot_alloc[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        lv_chk_slot #(
            .WIDTH        (WIDTH),
            .MAX_LEN      (MAX_LEN),
            .TIMEOUT_FAIL (TIMEOUT_FAIL)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .alloc    (slot_alloc[g]),
            .e        (e),
            .a        (a),
            .b        (b),
            .c        (c),
            .d        (d),
            .active   (slot_active[g]),
            .res_pass (res_pass[g]),
            .res_fail (res_fail[g]),
            .res_code (res_code[2*g +: 2])
        );
    end

    // Saturating next values for the statistics counters
    always_comb begin
        pass_sum = {1'b0, pass_cnt} + (CNT_W + 1)'(popcount(64'(res_pass)));
        fail_sum = {1'b0, fail_cnt} + (CNT_W + 1)'(popcount(64'(res_fail)));
        if (pass_sum > CNT_MAX) pass_sum = CNT_MAX;
        if (fail_sum > CNT_MAX) fail_sum = CNT_MAX;
    end

    // Registered pulses, counters (updated together with the pulses) and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_vec  <= '0;
            fail_vec  <= '0;
            fail_code <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            pass_vec  <= res_pass;
            fail_vec  <= res_fail;
            fail_code <= res_code;
            pass_cnt  <= pass_sum[CNT_W-1:0];
            fail_cnt  <= fail_sum[CNT_W-1:0];
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lv_capture_checker.sv
// Directed bench for lv_capture_checker. Main instance uses default
// parameters; two short-timeout instances (MAX_LEN=4) share the same inputs
// to cover strict and weak timeout, the weak one with a 2-bit counter to
// exercise saturation.
module tb_lv_capture_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       trig;
    logic [7:0] e;
    logic [7:0] a;
    logic       b;
    logic       c;
    logic [7:0] d;

    logic [3:0]  pass_vec,  fail_vec;
    logic [7:0]  fail_code;
    logic [15:0] pass_cnt,  fail_cnt;
    logic        overflow,  busy;

    logic [3:0]  t1_pass_vec, t1_fail_vec;
    logic [7:0]  t1_fail_code;
    logic [15:0] t1_pass_cnt, t1_fail_cnt;
    logic        t1_overflow, t1_busy;

    logic [3:0]  t0_pass_vec, t0_fail_vec;
    logic [7:0]  t0_fail_code;
    logic [1:0]  t0_pass_cnt, t0_fail_cnt;
    logic        t0_overflow, t0_busy;

    int n_tests = 0;
    int n_fail  = 0;

    lv_capture_checker u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .e(e), .a(a), .b(b), .c(c), .d(d),
        .pass_vec(pass_vec), .fail_vec(fail_vec), .fail_code(fail_code),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .overflow(overflow), .busy(busy)
    );

    lv_capture_checker #(.MAX_LEN(4), .TIMEOUT_FAIL(1)) u_to1 (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .e(e), .a(a), .b(b), .c(c), .d(d),
        .pass_vec(t1_pass_vec), .fail_vec(t1_fail_vec), .fail_code(t1_fail_code),
        .pass_cnt(t1_pass_cnt), .fail_cnt(t1_fail_cnt), .overflow(t1_overflow), .busy(t1_busy)
    );

    lv_capture_checker #(.MAX_LEN(4), .TIMEOUT_FAIL(0), .CNT_W(2)) u_to0 (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .e(e), .a(a), .b(b), .c(c), .d(d),
        .pass_vec(t0_pass_vec), .fail_vec(t0_fail_vec), .fail_code(t0_fail_code),
        .pass_cnt(t0_pass_cnt), .fail_cnt(t0_fail_cnt), .overflow(t0_overflow), .busy(t0_busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trig = 1'b0;
        e    = '0;
        a    = '0;
        b    = 1'b0;
        c    = 1'b0;
        d    = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_pass_vec",  32'(pass_vec),  0);
        chk("rst_fail_vec",  32'(fail_vec),  0);
        chk("rst_fail_code", 32'(fail_code), 0);
        chk("rst_pass_cnt",  32'(pass_cnt),  0);
        chk("rst_fail_cnt",  32'(fail_cnt),  0);
        chk("rst_overflow",  32'(overflow),  0);
        chk("rst_busy",      32'(busy),      0);
        rst_n = 1'b1;
        tick();

        // Basic pass
        trig = 1'b1; e = 8'h5A;
        tick();
        trig = 1'b0; a = 8'h5A; b = 1'b1; c = 1'b1; d = 8'h5A;
        chk("basic_busy_t1", 32'(busy), 1);
        tick();
        chk("basic_no_pulse_t2", 32'(pass_vec), 0);
        a = 8'h00; c = 1'b0;
        tick();
        chk("basic_pass_t3",  32'(pass_vec), 32'h1);
        chk("basic_cnt_t3",   32'(pass_cnt), 1);
        chk("basic_fail_t3",  32'(fail_vec), 0);
        chk("basic_free_t3",  32'(busy),     0);
        idle();
        tick();
        chk("basic_pulse_one_cycle", 32'(pass_vec), 0);

        // Shortest attempt, arm A fail
        trig = 1'b1; e = 8'h33;
        tick();
        trig = 1'b0; a = 8'h33; b = 1'b0; c = 1'b0;
        tick();
        idle();
        chk("armA_fail_vec",  32'(fail_vec),  32'h1);
        chk("armA_fail_code", 32'(fail_code), 32'h01);
        chk("armA_fail_cnt",  32'(fail_cnt),  1);
        tick();

        // Arm C fail after one good repetition
        trig = 1'b1; e = 8'h10;
        tick();
        trig = 1'b0; a = 8'h00; c = 1'b1; d = 8'h10;
        tick();
        d = 8'h11;
        chk("armC_no_pulse_t2", 32'(fail_vec), 0);
        tick();
        idle();
        chk("armC_fail_vec",  32'(fail_vec),  32'h1);
        chk("armC_fail_code", 32'(fail_code), 32'h02);
        chk("armC_fail_cnt",  32'(fail_cnt),  2);
        tick();

        // Same-cycle double failure reports arm A
        trig = 1'b1; e = 8'h44;
        tick();
        trig = 1'b0; a = 8'h44; b = 1'b0; c = 1'b1; d = 8'h45;
        tick();
        idle();
        chk("dbl_fail_code", 32'(fail_code), 32'h01);
        chk("dbl_fail_cnt",  32'(fail_cnt),  3);
        tick();

        // Timeout: MAX_LEN=4 instances resolve at t4, pulse at t5
        trig = 1'b1; e = 8'h77;
        tick();
        trig = 1'b0; a = 8'h00; c = 1'b1; d = 8'h77;
        tick();
        tick();
        tick();
        chk("to1_no_early_fail", 32'(t1_fail_vec), 0);
        chk("to0_no_early_pass", 32'(t0_pass_vec), 0);
        tick();
        chk("to1_fail_vec",  32'(t1_fail_vec),  32'h1);
        chk("to1_fail_code", 32'(t1_fail_code), 32'h03);
        chk("to0_pass_vec",  32'(t0_pass_vec),  32'h1);
        chk("to0_fail_vec",  32'(t0_fail_vec),  0);
        chk("main_still_busy", 32'(busy),     1);
        chk("main_no_fail",    32'(fail_vec), 0);
        c = 1'b0;
        tick();
        chk("main_late_pass", 32'(pass_vec), 32'h1);
        chk("main_pass_cnt2", 32'(pass_cnt), 2);
        idle();
        tick();

        // en=0 blocks allocation and does not flag overflow
        en = 1'b0; trig = 1'b1; e = 8'h05;
        tick();
        en = 1'b1; idle();
        chk("en0_not_busy",  32'(busy),     0);
        chk("en0_no_ovf",    32'(overflow), 0);
        tick();

        // Overlap and overflow: four attempts held, fifth dropped
        trig = 1'b1; e = 8'h01;
        tick();
        e = 8'h01; a = 8'h01; b = 1'b1; c = 1'b0;
        tick();
        e = 8'h02;
        tick();
        e = 8'h02; c = 1'b1; d = 8'h02;
        tick();
        e = 8'h05;
        chk("ovf_not_yet", 32'(overflow), 0);
        tick();
        trig = 1'b0;
        chk("ovf_set",       32'(overflow), 1);
        chk("ovf_busy",      32'(busy),     1);
        chk("ovf_no_pass",   32'(pass_vec), 0);
        chk("ovf_no_fail",   32'(fail_vec), 0);
        c = 1'b0;
        tick();
        chk("ovf_pass_slots23", 32'(pass_vec), 32'hC);
        chk("ovf_pass_cnt",     32'(pass_cnt), 4);
        b = 1'b0;
        tick();
        chk("ovf_fail_slots01", 32'(fail_vec),  32'h3);
        chk("ovf_fail_code",    32'(fail_code), 32'h05);
        chk("ovf_fail_cnt",     32'(fail_cnt),  5);
        chk("ovf_all_free",     32'(busy),      0);
        chk("ovf_sticky",       32'(overflow),  1);
        chk("to0_cnt_saturate", 32'(t0_pass_cnt), 3);
        idle();
        tick();

        // Reset mid-operation with two live attempts
        trig = 1'b1; e = 8'h21;
        tick();
        e = 8'h22; a = 8'h21; b = 1'b1; c = 1'b0;
        tick();
        trig = 1'b0; c = 1'b1; d = 8'h22;
        chk("midrst_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_async_clear", 32'(busy), 0);
        tick();
        idle();
        rst_n = 1'b1;
        chk("midrst_pass_vec", 32'(pass_vec), 0);
        chk("midrst_fail_vec", 32'(fail_vec), 0);
        chk("midrst_pass_cnt", 32'(pass_cnt), 0);
        chk("midrst_fail_cnt", 32'(fail_cnt), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        trig = 1'b1; e = 8'h30;
        tick();
        trig = 1'b0; a = 8'h00; c = 1'b0;
        chk("post_rst_busy", 32'(busy), 1);
        tick();
        chk("post_rst_slot0_pass", 32'(pass_vec), 32'h1);
        chk("post_rst_pass_cnt",   32'(pass_cnt), 1);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
